// File: rtl/mem_port_arbiter_if.sv
// Bundled fetch, load/store, memory and stall signals of the shared memory port.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-port memory: IDLE/ISSUE/WAIT/RESP
// sequencing, anti-starvation for fetch, completion pulses and core stall.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  is_d;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_t                r_state, w_next;
  cmd_t                  r_cmd;
  logic [SW-1:0]         r_streak;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_if_rdata, r_d_rdata;

  logic w_any_req, w_streak_max, w_grant_d, w_last_wait;
  logic w_mem_en, w_mem_we, w_if_ready, w_d_ready, w_stall;

  assign w_any_req    = bus.if_req | bus.d_req;
  assign w_streak_max = (r_streak == SW'(STARVE_LIMIT));
  // data has priority until fetch has waited through STARVE_LIMIT data grants
  assign w_grant_d    = bus.d_req & (~bus.if_req | ~w_streak_max);

  always_comb begin
    w_next      = r_state;
    w_last_wait = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_if_ready  = 1'b0;
    w_d_ready   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: begin
        w_mem_en = 1'b1;
        w_mem_we = r_cmd.we;
        w_next   = S_WAIT;
      end
      S_WAIT: if (r_cnt == CW'(1)) begin
        w_last_wait = 1'b1;
        w_next      = S_RESP;
      end
      S_RESP: begin
        w_if_ready = ~r_cmd.is_d;
        w_d_ready  = r_cmd.is_d;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // gated by reset so every output reads 0 while reset is held
    w_stall = ~reset & ((bus.if_req & ~w_if_ready) | (bus.d_req & ~w_d_ready));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd      <= '0;
      r_streak   <= '0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_cmd.is_d  <= w_grant_d;
        r_cmd.we    <= w_grant_d & bus.d_we;
        r_cmd.addr  <= w_grant_d ? bus.d_addr : bus.if_addr;
        r_cmd.wdata <= w_grant_d ? bus.d_wdata : '0;
        if (w_grant_d && bus.if_req) begin
          if (!w_streak_max) r_streak <= r_streak + 1'b1;
        end else begin
          r_streak <= '0;
        end
      end
      if (r_state == S_ISSUE)     r_cnt <= CW'(MEM_LATENCY);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_last_wait) begin
        if (!r_cmd.is_d)    r_if_rdata <= bus.mem_rdata;
        else if (!r_cmd.we) r_d_rdata  <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.if_ready  = w_if_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ready   = w_d_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall     = w_stall;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// on a MEM_LATENCY=1 instance, plus literal checks incl. a MEM_LATENCY=3 instance.
module tb_mem_port_arbiter;
  localparam int L0 = 1;
  localparam int L1 = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u0 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u1 ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L0), .STARVE_LIMIT(SL))
    dut0 (.clk(clk), .reset(reset), .bus(u0.slave));
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L1), .STARVE_LIMIT(SL))
    dut1 (.clk(clk), .reset(reset), .bus(u1.slave));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0200: return 32'h1234_5678;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // ---------------- transaction model + memory for instance 0 ----------------
  logic [31:0] tb_mem    [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  int          cyc = 0;
  bit          m_busy = 0, m_isd = 0, m_we = 0;
  int          m_issue = 0, m_ready = 0, m_streak = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ifr = '0, m_dr = '0;
  int          pend_t = -1;
  logic [31:0] pend_addr = '0, nxt_rdata = '0;

  always @(negedge clk) begin
    bit e_en, e_ifr, e_dr, win_d;
    cyc++;
    if (reset) begin
      chk("rst_mem_en", u0.mem_en, 0);
      chk("rst_mem_we", u0.mem_we, 0);
      chk("rst_mem_addr", u0.mem_addr, 0);
      chk("rst_if_ready", u0.if_ready, 0);
      chk("rst_d_ready", u0.d_ready, 0);
      chk("rst_if_rdata", u0.if_rdata, 0);
      chk("rst_d_rdata", u0.d_rdata, 0);
      chk("rst_stall", u0.stall, 0);
      m_busy = 0; m_streak = 0; m_addr = '0; m_wdata = '0;
      m_we = 0; m_isd = 0; m_ifr = '0; m_dr = '0;
      pend_t = -1;
    end else begin
      if (m_busy && cyc == m_ready) begin
        if (!m_isd)     m_ifr = model_mem.exists(m_addr) ? model_mem[m_addr] : init_val(m_addr);
        else if (!m_we) m_dr  = model_mem.exists(m_addr) ? model_mem[m_addr] : init_val(m_addr);
      end
      e_en  = m_busy && cyc == m_issue;
      e_ifr = m_busy && cyc == m_ready && !m_isd;
      e_dr  = m_busy && cyc == m_ready && m_isd;
      chk("mem_en", u0.mem_en, e_en);
      chk("mem_we", u0.mem_we, e_en & m_we);
      if (m_busy) chk("mem_addr", u0.mem_addr, m_addr);
      if (e_en && m_we) chk("mem_wdata", u0.mem_wdata, m_wdata);
      chk("if_ready", u0.if_ready, e_ifr);
      chk("d_ready", u0.d_ready, e_dr);
      chk("if_rdata", u0.if_rdata, m_ifr);
      chk("d_rdata", u0.d_rdata, m_dr);
      chk("stall", u0.stall, (u0.if_req & ~e_ifr) | (u0.d_req & ~e_dr));

      if (m_busy && cyc == m_ready) begin
        m_busy = 0;
      end else if (!m_busy && (u0.if_req || u0.d_req)) begin
        win_d   = u0.d_req && !(u0.if_req && m_streak == SL);
        m_busy  = 1;
        m_issue = cyc + 1;
        m_ready = cyc + 2 + L0;
        m_isd   = win_d;
        if (win_d) begin
          m_we    = u0.d_we;
          m_addr  = u0.d_addr;
          m_wdata = u0.d_wdata;
          if (u0.d_we) model_mem[u0.d_addr] = u0.d_wdata;
          m_streak = u0.if_req ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
        end else begin
          m_we     = 0;
          m_addr   = u0.if_addr;
          m_streak = 0;
        end
      end

      if (u0.mem_en) begin
        if (u0.mem_we) tb_mem[u0.mem_addr] = u0.mem_wdata;
        else begin
          pend_t    = cyc + L0;
          pend_addr = u0.mem_addr;
        end
      end
    end
    // memory answers only on the cycle the read data is due; junk otherwise
    nxt_rdata = (cyc + 1 == pend_t)
              ? (tb_mem.exists(pend_addr) ? tb_mem[pend_addr] : init_val(pend_addr))
              : (32'hBAD0_0000 ^ (cyc + 1));
  end

  always @(posedge clk) begin
    #1;
    u0.mem_rdata = nxt_rdata;
  end

  // requester: call at posedge+1; returns cycles from request to ready (-1 on timeout)
  task automatic xact(input bit is_d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, output int lat);
    if (is_d) begin
      u0.d_req = 1'b1; u0.d_we = we; u0.d_addr = a; u0.d_wdata = wd;
    end else begin
      u0.if_req = 1'b1; u0.if_addr = a;
    end
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      #2;
      if (is_d ? u0.d_ready : u0.if_ready) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (is_d) u0.d_req = 1'b0;
    else      u0.if_req = 1'b0;
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int lf, ld, got;
    logic [31:0] gd;
    u0.if_req = 0; u0.if_addr = '0; u0.d_req = 0; u0.d_we = 0; u0.d_addr = '0; u0.d_wdata = '0;
    u1.if_req = 0; u1.if_addr = '0; u1.d_req = 0; u1.d_we = 0; u1.d_addr = '0; u1.d_wdata = '0;
    u1.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_mem_en", u0.mem_en, 0);
    chk("lit_rst_if_rdata", u0.if_rdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    xact(0, 0, 32'h10, 0, lf);
    chk("fetch_lat", lf, 3);
    chk("fetch_data", u0.if_rdata, 32'h0050_0093);

    xact(1, 1, 32'h100, 32'hDEAD_BEEF, ld);
    chk("store_lat", ld, 3);
    chk("store_keeps_d_rdata", u0.d_rdata, 0);

    fork
      xact(0, 0, 32'h14, 0, lf);
      xact(1, 0, 32'h200, 0, ld);
    join
    chk("both_d_lat", ld, 3);
    chk("both_f_lat", lf, 7);
    chk("both_d_data", u0.d_rdata, 32'h1234_5678);
    chk("both_f_data", u0.if_rdata, 32'hC0DE_0014);

    xact(1, 0, 32'h100, 0, ld);
    chk("load_after_store", u0.d_rdata, 32'hDEAD_BEEF);

    fork
      xact(0, 0, 32'h20, 0, lf);
      for (int i = 0; i < 5; i++) begin
        xact(1, 0, 32'h300 + 4 * i, 0, ld);
        chk("starve_d_lat", ld, (i < SL) ? 3 : 7);
      end
    join
    chk("starve_f_lat", lf, 19);

    fork
      xact(0, 0, 32'h24, 0, lf);
      xact(1, 0, 32'h28, 0, ld);
    join
    chk("streak_clr_d_lat", ld, 3);
    chk("streak_clr_f_lat", lf, 7);

    // reset during WAIT of a load
    u0.d_req = 1; u0.d_we = 0; u0.d_addr = 32'h400;
    @(posedge clk); #3;
    chk("rst_seq_issue", u0.mem_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_mem_en", u0.mem_en, 0);
    chk("async_mem_addr", u0.mem_addr, 0);
    chk("async_d_ready", u0.d_ready, 0);
    chk("async_d_rdata", u0.d_rdata, 0);
    chk("async_stall", u0.stall, 0);
    @(posedge clk); #1;
    u0.d_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    xact(0, 0, 32'h10, 0, lf);
    chk("post_rst_lat", lf, 3);
    chk("post_rst_data", u0.if_rdata, 32'h0050_0093);

    // MEM_LATENCY=3 instance: memory value changes every cycle
    u1.if_addr = 32'h40; u1.if_req = 1; got = -1; gd = '0;
    for (int k = 0; k < 12; k++) begin
      u1.mem_rdata = 32'hA000_0000 | k;
      #2;
      if (k == 1) chk("l3_issue", u1.mem_en, 1);
      if (k == 0) chk("l3_stall", u1.stall, 1);
      if (u1.if_ready) begin
        got = k;
        gd  = u1.if_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    chk("l3_lat", got, 5);
    chk("l3_data", gd, 32'hA000_0004);
    @(posedge clk); #1;
    u1.if_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("l3_idle", u1.stall, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch path and the load/store path of the RISC-V core.
- The data side is driven by the decoder's memory_read/memory_write outputs.
- Sequences each access through a fixed issue/wait/respond FSM and returns a one-cycle completion pulse to the winning requester.
- Generates the core-wide stall that holds PC and register writeback while an access is pending.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (>=1)
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request (level)
if_addr  input  ADDR_WIDTH  fetch address (PC)
if_ready  output  1  one-cycle fetch completion pulse
if_rdata  output  DATA_WIDTH  fetched instruction, valid with if_ready and held until next fetch completion
d_req  input  1  data request (memory_read | memory_write)
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_WIDTH  load/store address from ALU
d_wdata  input  DATA_WIDTH  store data
d_ready  output  1  one-cycle data completion pulse
d_rdata  output  DATA_WIDTH  load data, valid with d_ready and held until next load completion
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data
stall  output  1  core hold

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0; rdata registers 0.
  - FSM in IDLE; streak counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either req is high, arbitrate, latch the winner's id, addr, we and wdata into the command registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration when both requests are high:
  - Data wins unless streak == STARVE_LIMIT; in that case fetch wins.
  - When only one request is high, it wins.
  - A fetch grant clears streak.
  - A data grant while if_req is high increments streak, saturating at STARVE_LIMIT.
  - A data grant while if_req is low clears streak.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we = latched we (always 0 for fetch).
  - mem_addr and mem_wdata come from the command registers.
  - Counter loads MEM_LATENCY; go to WAIT.
- WAIT (MEM_LATENCY cycles):
  - mem_en=0; mem_addr stays held.
  - On the last WAIT cycle, capture mem_rdata into if_rdata (fetch) or d_rdata (load). Stores capture nothing.
  - Then go to RESP.
- RESP (1 cycle):
  - The matching ready output is 1, registered; then go to IDLE.
- Latency: a request first seen in IDLE at cycle T gets ready at cycle T+2+MEM_LATENCY. With the default, that is T+3.
- Request rules:
  - The requester holds req, addr, we and wdata stable until its ready pulse.
  - The requester updates or drops them at the clock edge that ends the ready cycle.
  - Req high in IDLE is always treated as a new request.
  - Changes to a requester's inputs while it is granted are ignored; the command registers hold.
- stall = (if_req & ~if_ready) | (d_req & ~d_ready). It is combinational and 0 in the cycle of a completion.
- A request that loses arbitration waits in IDLE and is served on the next pass. No request is dropped.
- Reset mid-operation:
  - Immediately returns to IDLE, mem_en=0, ready=0.
  - The in-flight transaction is abandoned; a store in ISSUE is not guaranteed.
- Addresses pass through unaligned and unmodified. No error reporting.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, mem returns 0x0050_0093 one cycle after mem_en -> mem_en=1 at T+1 with mem_addr=0x10, if_ready=1 at T+3 with if_rdata=0x0050_0093, stall high T..T+2.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> one cycle with mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; d_ready at T+3; d_rdata unchanged.
- Simultaneous if_req and d_req (load 0x200) -> data is granted first (d_ready at T+3); fetch ISSUE follows at T+5 and if_ready comes at T+7.
- if_req held while d_req is re-raised every completion -> exactly 4 data grants, then 1 fetch grant; streak returns to 0.
- MEM_LATENCY=3 -> ready at T+5; if_rdata equals the mem_rdata sampled on the 3rd WAIT cycle.
- Reset asserted during WAIT of a load -> all outputs 0 asynchronously; d_ready never pulses; after reset release the next request behaves like the first scenario.
